serial_chunk_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder: sum = a + b + ci, computed CHUNK bits per cycle through a

---
 rtl/adder_pkg.sv | 19 +
 rtl/fa_cell.sv | 14 +
 rtl/serial_chunk_adder.sv | 122 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and width helper
// for the chunked serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never below 1 bit
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder, one link of the
// per-cycle ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit add done CHUNK bits
// per cycle, carry held in a register between chunks.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK >= 1");
  end

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = clog2w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      off;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic [CHUNK:0]   cc;
  logic             last;

  // chunk operand select: a mux on the chunk index
  assign off  = 32'(idx_q) * 32'(CHUNK);
  assign ca   = a_q[off +: CHUNK];
  assign cb   = b_q[off +: CHUNK];
  assign cc[0] = carry_q;
  assign last = (idx_q == LAST);

  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    fa_cell u_fa (
      .a  (ca[i]),
      .b  (cb[i]),
      .ci (cc[i]),
      .s  (cs[i]),
      .co (cc[i+1])
    );
  end

  // next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      (state_q == RUN): begin
        if (last) state_d = DONE;
      end
      (state_q == DONE): begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // all state: operands, carry, index, result, flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= ci;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        sum_q[off +: CHUNK] <= cs;
        carry_q <= cc[CHUNK];
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          cout_q <= cc[CHUNK];
          ovf_q  <= cc[CHUNK] ^ cc[CHUNK-1];
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed scoreboard checks on
// 16/4, then random traffic on 16/1, 16/16 and 8/2.
module tb_serial_chunk_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int fails  = 0;
  bit dir_done = 0;

  localparam int NRAND = 1000;

  logic [17:0] mq[$];

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // main monitor: compare on every result handshake
  always begin
    logic [17:0] e;
    @(negedge clk);
    #1;
    if (out_valid && out_ready) begin
      chk("main_q_nonempty", 32'(mq.size() != 0), 1);
      if (mq.size() != 0) begin
        e = mq.pop_front();
        chk("sum", sum, e[15:0]);
        chk("cout", cout, e[16]);
        chk("ovf", ovf, e[17]);
      end
    end
  end

  task automatic run_op(input logic [15:0] ta,
                        input logic [15:0] tb,
                        input logic        tci,
                        input logic [15:0] es,
                        input logic        ec,
                        input logic        eo,
                        input bit          hold);
    int k;
    chk("idle_in_ready", in_ready, 1);
    a = ta;
    b = tb;
    ci = tci;
    in_valid = 1'b1;
    mq.push_back({eo, ec, es});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("run_in_ready", in_ready, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk("latency", k, 4);
    if (hold) begin
      in_valid = 1'b1;
      a = 16'hAAAA;
      b = 16'h5555;
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_sum", sum, es);
        chk("hold_cout", cout, ec);
        chk("hold_ovf", ovf, eo);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("keep_sum", sum, es);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    // abort in the second RUN cycle
    a = 16'hFFFF;
    b = 16'h1234;
    ci = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("run_chunk0", sum[3:0], 4'h3);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    chk("main_drain", mq.size(), 0);
    dir_done = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W = (g == 2) ? 8 : 16;
    localparam int C = (g == 0) ? 1 : (g == 1) ? 16 : 2;

    logic         iv;
    logic         ir;
    logic         ov;
    logic         ordy;
    logic         co;
    logic         of;
    logic         rci;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] s;
    logic [W+1:0] q[$];
    bit           fin = 0;

    serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .ci        (rci),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (s),
      .cout      (co),
      .ovf       (of)
    );

    initial begin
      ordy = 1'b0;
      forever begin
        @(negedge clk);
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always begin
      logic [W+1:0] e;
      @(negedge clk);
      #1;
      if (ov && ordy) begin
        chk($sformatf("rnd%0d_q_nonempty", g),
            32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("rnd%0d_sum", g), 32'(s), 32'(e[W-1:0]));
          chk($sformatf("rnd%0d_cout", g), co, e[W]);
          chk($sformatf("rnd%0d_ovf", g), of, e[W+1]);
        end
      end
    end

    initial begin
      logic [W:0] full;
      logic       eo;
      int t;
      int k;
      iv = 1'b0;
      ra = '0;
      rb = '0;
      rci = 1'b0;
      wait (dir_done);
      for (int n = 0; n < NRAND; n++) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        ra = W'($urandom);
        rb = W'($urandom);
        rci = 1'($urandom);
        iv = 1'b1;
        t = 0;
        while (!ir && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!ir) begin
          chk($sformatf("rnd%0d_accept", g), ir, 1);
          iv = 1'b0;
          break;
        end
        full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
        eo = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
        q.push_back({eo, full});
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        k = 0;
        while (!ov && k < 40) begin
          @(posedge clk);
          k++;
          @(negedge clk);
        end
        chk($sformatf("rnd%0d_latency", g), k, W / C);
      end
      t = 0;
      while (q.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("rnd%0d_drain", g), q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(rnd[0].fin && rnd[1].fin && rnd[2].fin)
           && t < 90000) begin
      @(negedge clk);
      t++;
    end
    chk("all_done", 32'(rnd[0].fin && rnd[1].fin && rnd[2].fin), 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
